axi_burst_master: RTL and testbench



---
 rtl/axi_burst_master_pkg.sv | 32 +++
 rtl/axi_burst_master_if.sv | 65 ++++++
 rtl/axi_burst_master_beat_ctr.sv | 27 ++
 rtl/axi_burst_master.sv | 176 +++++++++++++++++
 tb/tb_axi_burst_master.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_master_pkg.sv
// Shared definitions for the AXI4 burst master.
// Contents: FSM state enum, AXI response codes, burst type encoding,
// and the AXI size encoding helper for the data bus width.
package axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRESP = 3'd3,
        ST_RADDR = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // AxSIZE = log2(bytes per beat); only 32/64/128-bit buses are legal.
    function automatic logic [2:0] size_enc(input int data_w);
        case (data_w)
            64:      return 3'd3;
            128:     return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) between the burst master and a slave.
// Parameters: ADDR_W address width, DATA_W data width (wstrb is DATA_W/8).
// Modports: master drives AW/W/AR payload+valid and B/R ready;
//           slave is the mirror image.
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_master_beat_ctr.sv
// axim_beat_ctr: 8-bit beat counter shared by the W and R data phases.
// Ports: aclk/areset (async active-low), clear (zero the count, wins over inc),
//        inc (one data handshake), len (latched beats-1), is_last (count == len).
module axim_beat_ctr (
    input  logic       aclk,
    input  logic       areset,
    input  logic       clear,
    input  logic       inc,
    input  logic [7:0] len,
    output logic       is_last
);

    logic [7:0] count;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign is_last = (count == len);

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: runs one AXI4 INCR burst per accepted command.
// Ports:
//   aclk, areset (async active-low)
//   cmd_*   : command handshake (write flag, start address, beats-1)
//   wr_*    : write-data stream in, passed straight through to W
//   rd_*    : read-data stream out, passed straight through from R
//   done/resp : one-cycle completion pulse and final response (held until
//               the next command is accepted)
//   axi     : AXI4 master modport (AW, W, B, AR, R)
// Build option: AXIM_4K_GUARD_EN rejects bursts crossing a 4 KB boundary
//   (SLVERR, no bus activity). Undefined: bursts issued as given.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,

    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,

    output logic              done,
    output logic [1:0]        resp,

    axi_burst_master_if.master axi
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] WADDR = ST_WADDR;
    localparam logic [2:0] WDATA = ST_WDATA;
    localparam logic [2:0] WRESP = ST_WRESP;
    localparam logic [2:0] RADDR = ST_RADDR;
    localparam logic [2:0] RDATA = ST_RDATA;
    localparam logic [2:0] DONE  = ST_DONE;

    localparam logic [2:0] AXI_SIZE  = size_enc(DATA_W);
    localparam logic [8:0] LEN_LIMIT = 9'(MAX_LEN - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [1:0]        resp_q;
    logic [1:0]        r_resp_next;

    logic cmd_hs;
    logic w_hs;
    logic r_hs;
    logic beat_last;
    logic len_bad;
    logic cmd_reject;

    assign len_bad = ({1'b0, cmd_len} > LEN_LIMIT);

`ifdef AXIM_4K_GUARD_EN
    localparam logic [13:0] BEAT_BYTES = 14'(DATA_W / 8);
    logic [13:0] burst_end;
    // Byte offset one past the last beat, relative to the 4 KB page start.
    assign burst_end  = {2'b00, cmd_addr[11:0]} + ({6'd0, cmd_len} + 14'd1) * BEAT_BYTES;
    assign cmd_reject = len_bad || (burst_end > 14'd4096);
`else
    assign cmd_reject = len_bad;
`endif

    // Gated by areset so no ready is seen while reset is held.
    assign cmd_ready = areset && (state == IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign w_hs      = (state == WDATA) && wr_valid && axi.wready;
    assign r_hs      = (state == RDATA) && axi.rvalid && rd_ready;

    axim_beat_ctr u_beat_ctr (
        .aclk    (aclk),
        .areset  (areset),
        .clear   (cmd_hs),
        .inc     (w_hs || r_hs),
        .len     (len_q),
        .is_last (beat_last)
    );

    // Worst response so far; an rlast that disagrees with our own beat count
    // is a protocol error and is reported as at least SLVERR.
    always_comb begin
        r_resp_next = resp_q;
        if (axi.rresp > r_resp_next) begin
            r_resp_next = axi.rresp;
        end
        if ((axi.rlast != beat_last) && (r_resp_next < RESP_SLVERR)) begin
            r_resp_next = RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            resp_q <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        if (cmd_reject) begin
                            resp_q <= RESP_SLVERR;
                            state  <= DONE;
                        end else begin
                            resp_q <= RESP_OKAY;
                            state  <= cmd_write ? WADDR : RADDR;
                        end
                    end
                end
                WADDR: if (axi.awready) state <= WDATA;
                WDATA: if (w_hs && beat_last) state <= WRESP;
                WRESP: begin
                    if (axi.bvalid) begin
                        resp_q <= axi.bresp;
                        state  <= DONE;
                    end
                end
                RADDR: if (axi.arready) state <= RDATA;
                RDATA: begin
                    if (r_hs) begin
                        resp_q <= r_resp_next;
                        if (beat_last) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign axi.awvalid = (state == WADDR);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = AXI_SIZE;
    assign axi.awburst = BURST_INCR;

    assign axi.arvalid = (state == RADDR);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = AXI_SIZE;
    assign axi.arburst = BURST_INCR;

    assign axi.wvalid  = (state == WDATA) && wr_valid;
    assign wr_ready    = (state == WDATA) && axi.wready;
    assign axi.wdata   = wr_data;
    assign axi.wstrb   = '1;
    assign axi.wlast   = (state == WDATA) && beat_last;

    assign axi.bready  = (state == WRESP);

    assign rd_valid    = (state == RDATA) && axi.rvalid;
    assign axi.rready  = (state == RDATA) && rd_ready;
    assign rd_data     = axi.rdata;
    assign rd_last     = (state == RDATA) && beat_last;

    assign done = (state == DONE);
    assign resp = resp_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master (DATA_W=32, MAX_LEN=16).
// A directed table of commands plus randomized commands run against a
// transaction-level slave/source/sink; expected responses come from a
// small rule-based model. A hand sequence covers reset in mid-burst.
module tb_axi_burst_master;
    import axi_master_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 16;
    localparam int BYTES   = DATA_W / 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, rd_ready, rd_last;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic [1:0]        resp;

    axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .resp      (resp),
        .axi       (bus)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [1:0]        rr_tbl [257];
    int                bad_rlast;
    logic [DATA_W-1:0] wpat [257];
    logic [DATA_W-1:0] rpat [257];

    typedef struct {
        string      name;
        bit         wr;
        logic [31:0] addr;
        logic [7:0] len;
        logic [1:0] bresp;
        logic [1:0] hot_resp;
        int         hot_beat;
        int         bad;
        int         pct;
        logic [1:0] exp_resp;
        int         exp_beats;
        int         exp_cycles;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic bit model_reject(input logic [31:0] addr, input int len);
        if (len > MAX_LEN - 1) return 1'b1;
`ifdef AXIM_4K_GUARD_EN
        if (int'(addr % 4096) + (len + 1) * BYTES > 4096) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [1:0] model_resp(input bit wr, input logic [31:0] addr,
                                              input int len, input logic [1:0] b);
        int worst;
        if (model_reject(addr, len)) return 2'b10;
        if (wr) return b;
        worst = 0;
        for (int i = 0; i <= len; i++) begin
            if (int'(rr_tbl[i]) > worst) worst = int'(rr_tbl[i]);
            if (i == bad_rlast && worst < 2) worst = 2;
        end
        return 2'(worst);
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 2'b00;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 0;
    endtask

    task automatic add_vec(input string nm, input bit wr, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] b,
                           input logic [1:0] hot_resp, input int hot_beat, input int bad,
                           input int pct, input logic [1:0] er, input int eb, input int ec);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = addr; v.len = len; v.bresp = b;
        v.hot_resp = hot_resp; v.hot_beat = hot_beat; v.bad = bad; v.pct = pct;
        v.exp_resp = er; v.exp_beats = eb; v.exp_cycles = ec;
        vt.push_back(v);
    endtask

    task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] bresp_v, input int pct,
                           input logic [1:0] exp_resp, input int exp_beats, input int exp_cycles);
        bit accepted, aw_seen, aw_done, ar_seen, ar_done, w_all, b_done, got_done;
        bit order_ok, wbeat_ok, rbeat_ok, stable_ok, wrong_chan;
        int acc_cyc, addr_cyc, done_cyc, wbeats, wi, ri, rd_cnt, n;
        logic [ADDR_W-1:0] a_addr;
        logic [7:0]        a_len;
        logic [2:0]        a_size;
        logic [1:0]        a_burst;
        logic [1:0]        resp_got;

        accepted = 0; aw_seen = 0; aw_done = 0; ar_seen = 0; ar_done = 0;
        w_all = 0; b_done = 0; got_done = 0;
        order_ok = 1; wbeat_ok = 1; rbeat_ok = 1; stable_ok = 1; wrong_chan = 0;
        acc_cyc = -1; addr_cyc = -1; done_cyc = -1;
        wbeats = 0; wi = 0; ri = 0; rd_cnt = 0; n = int'(len);
        a_addr = '0; a_len = '0; a_size = '0; a_burst = '0; resp_got = '0;
        for (int i = 0; i < 257; i++) begin
            wpat[i] = $urandom;
            rpat[i] = $urandom;
        end
        cmd_write = wr; cmd_addr = addr; cmd_len = len;

        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge aclk);
            cmd_valid   = !accepted;
            bus.awready = roll(pct);
            bus.arready = roll(pct);
            bus.wready  = roll(pct);
            rd_ready    = roll(pct);
            if (!wr || wi > n) wr_valid = 0;
            else if (!wr_valid) wr_valid = roll(pct);
            wr_data = wpat[wi];
            if (!w_all || b_done) bus.bvalid = 0;
            else if (!bus.bvalid) bus.bvalid = roll(pct);
            bus.bresp = bresp_v;
            if (!ar_done || ri > n) bus.rvalid = 0;
            else if (!bus.rvalid) bus.rvalid = roll(pct);
            bus.rdata = rpat[ri];
            bus.rresp = rr_tbl[ri];
            bus.rlast = (ri == n) ^ (ri == bad_rlast);
            #1;
            if (cmd_valid && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
            if (bus.wvalid && !aw_done) order_ok = 0;
            if (aw_seen && !aw_done && !bus.awvalid) stable_ok = 0;
            if (ar_seen && !ar_done && !bus.arvalid) stable_ok = 0;
            if (bus.awvalid) begin
                if (!wr) wrong_chan = 1;
                if (!aw_seen) begin
                    aw_seen = 1; addr_cyc = cyc;
                    a_addr = bus.awaddr; a_len = bus.awlen; a_size = bus.awsize; a_burst = bus.awburst;
                end else if (bus.awaddr !== a_addr || bus.awlen !== a_len) stable_ok = 0;
                if (bus.awready) aw_done = 1;
            end
            if (bus.arvalid) begin
                if (wr) wrong_chan = 1;
                if (!ar_seen) begin
                    ar_seen = 1; addr_cyc = cyc;
                    a_addr = bus.araddr; a_len = bus.arlen; a_size = bus.arsize; a_burst = bus.arburst;
                end else if (bus.araddr !== a_addr || bus.arlen !== a_len) stable_ok = 0;
                if (bus.arready) ar_done = 1;
            end
            if (bus.wvalid && bus.wready) begin
                if (bus.wdata !== wpat[wbeats] || bus.wlast !== (wbeats == n) || bus.wstrb !== '1)
                    wbeat_ok = 0;
                wbeats++;
                if (wbeats == n + 1) w_all = 1;
            end
            if (wr_valid && wr_ready) wi++;
            if (bus.bvalid && bus.bready) b_done = 1;
            if (bus.rvalid && bus.rready) ri++;
            if (rd_valid && rd_ready) begin
                if (rd_data !== rpat[rd_cnt] || rd_last !== (rd_cnt == n)) rbeat_ok = 0;
                rd_cnt++;
            end
            if (done) begin got_done = 1; done_cyc = cyc; resp_got = resp; end
        end

        chk({name, " done_seen"}, 64'(got_done), 64'd1);
        if (got_done) begin
            chk({name, " resp"}, 64'(resp_got), 64'(exp_resp));
            chk({name, " beats"}, 64'(wr ? wbeats : rd_cnt), 64'(exp_beats));
            if (exp_beats == 0) begin
                chk({name, " bus_idle"}, 64'(aw_seen || ar_seen || wbeats != 0), 64'd0);
                chk({name, " accept_to_done"}, 64'(done_cyc - acc_cyc), 64'd1);
            end else begin
                chk({name, " channel"}, 64'(wrong_chan), 64'd0);
                chk({name, " addr_latency"}, 64'(addr_cyc - acc_cyc), 64'd1);
                chk({name, " axaddr"}, 64'(a_addr), 64'(addr));
                chk({name, " axlen"}, 64'(a_len), 64'(len));
                chk({name, " axsize"}, 64'(a_size), 64'd2);
                chk({name, " axburst"}, 64'(a_burst), 64'd1);
                chk({name, " addr_stable"}, 64'(stable_ok), 64'd1);
                if (wr) begin
                    chk({name, " wbeats_ok"}, 64'(wbeat_ok), 64'd1);
                    chk({name, " aw_before_w"}, 64'(order_ok), 64'd1);
                end else begin
                    chk({name, " rbeats_ok"}, 64'(rbeat_ok), 64'd1);
                end
            end
            if (exp_cycles > 0) chk({name, " total_cycles"}, 64'(done_cyc - acc_cyc), 64'(exp_cycles));
            @(negedge aclk);
            idle_inputs();
            #1;
            chk({name, " done_one_cycle"}, 64'(done), 64'd0);
            chk({name, " resp_hold"}, 64'(resp), 64'(resp_got));
            chk({name, " back_idle"}, 64'(cmd_ready), 64'd1);
        end
        idle_inputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad_seen;
        idle_inputs();
        bad_rlast = -1;
        for (int i = 0; i < 257; i++) rr_tbl[i] = 2'b00;
        areset = 0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst awvalid", 64'(bus.awvalid), 64'd0);
        chk("rst arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst wvalid", 64'(bus.wvalid), 64'd0);
        chk("rst wlast", 64'(bus.wlast), 64'd0);
        chk("rst bready", 64'(bus.bready), 64'd0);
        chk("rst rready", 64'(bus.rready), 64'd0);
        chk("rst rd_valid", 64'(rd_valid), 64'd0);
        chk("rst rd_last", 64'(rd_last), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst resp", 64'(resp), 64'd0);
        @(negedge aclk);
        areset = 1;
        #1;
        chk("rst release cmd_ready", 64'(cmd_ready), 64'd1);

        //        name            wr addr       len   bresp hot hotb bad  pct  resp  beats cyc
        add_vec("wr_len3",        1, 32'h100,  8'd3,  2'd0, 2'd0, -1, -1, 100, 2'd0, 4,  7);
        add_vec("wr_len0_min",    1, 32'h0,    8'd0,  2'd0, 2'd0, -1, -1, 100, 2'd0, 1,  4);
        add_vec("rd_len0_exokay", 0, 32'h80,   8'd0,  2'd0, 2'd1,  0, -1, 100, 2'd1, 1,  3);
        add_vec("rd_len7_decerr", 0, 32'h200,  8'd7,  2'd0, 2'd3,  3, -1,  50, 2'd3, 8,  0);
        add_vec("wr_len_max",     1, 32'h0,    8'd16, 2'd0, 2'd0, -1, -1, 100, 2'd2, 0,  0);
        add_vec("rd_len_max",     0, 32'h0,    8'd16, 2'd0, 2'd0, -1, -1, 100, 2'd2, 0,  0);
        add_vec("rd_len255",      0, 32'h0,    8'd255,2'd0, 2'd0, -1, -1, 100, 2'd2, 0,  0);
        add_vec("wr_len15_exok",  1, 32'h40,   8'd15, 2'd1, 2'd0, -1, -1,  70, 2'd1, 16, 0);
        add_vec("rd_early_rlast", 0, 32'h300,  8'd3,  2'd0, 2'd0, -1,  1, 100, 2'd2, 4,  0);
        add_vec("rd_no_rlast",    0, 32'h300,  8'd3,  2'd0, 2'd0, -1,  3, 100, 2'd2, 4,  0);
`ifdef AXIM_4K_GUARD_EN
        add_vec("wr_4k_cross",    1, 32'hFF8,  8'd3,  2'd0, 2'd0, -1, -1, 100, 2'd2, 0,  0);
`else
        add_vec("wr_4k_cross",    1, 32'hFF8,  8'd3,  2'd0, 2'd0, -1, -1, 100, 2'd0, 4,  0);
`endif
        add_vec("wr_4k_edge",     1, 32'hFF0,  8'd3,  2'd0, 2'd0, -1, -1, 100, 2'd0, 4,  0);
        add_vec("wr_decerr",      1, 32'h500,  8'd1,  2'd3, 2'd0, -1, -1,  60, 2'd3, 2,  0);
        add_vec("rd_slverr",      0, 32'h10,   8'd2,  2'd0, 2'd2,  0, -1,  80, 2'd2, 3,  0);

        foreach (vt[k]) begin
            for (int i = 0; i < 257; i++) rr_tbl[i] = 2'b00;
            if (vt[k].hot_beat >= 0) rr_tbl[vt[k].hot_beat] = vt[k].hot_resp;
            bad_rlast = vt[k].bad;
            run_txn(vt[k].name, vt[k].wr, vt[k].addr, vt[k].len, vt[k].bresp, vt[k].pct,
                    vt[k].exp_resp, vt[k].exp_beats, vt[k].exp_cycles);
        end

        // Reset while the second write beat is on the bus.
        bad_rlast = -1;
        for (int i = 0; i < 257; i++) rr_tbl[i] = 2'b00;
        @(negedge aclk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_len = 8'd3;
        #1;
        chk("rstmid accept", 64'(cmd_ready), 64'd1);
        @(negedge aclk);
        cmd_valid = 0; bus.awready = 1;
        #1;
        chk("rstmid awvalid", 64'(bus.awvalid), 64'd1);
        @(negedge aclk);
        bus.awready = 0; wr_valid = 1; wr_data = 32'h1111_1111; bus.wready = 1;
        #1;
        chk("rstmid beat1 wvalid", 64'(bus.wvalid), 64'd1);
        @(negedge aclk);
        wr_data = 32'h2222_2222;
        #1;
        chk("rstmid beat2 wvalid", 64'(bus.wvalid), 64'd1);
        chk("rstmid beat2 wlast", 64'(bus.wlast), 64'd0);
        areset = 0;
        #1;
        chk("rstmid wvalid drop", 64'(bus.wvalid), 64'd0);
        chk("rstmid awvalid drop", 64'(bus.awvalid), 64'd0);
        chk("rstmid done", 64'(done), 64'd0);
        chk("rstmid cmd_ready held", 64'(cmd_ready), 64'd0);
        @(negedge aclk);
        idle_inputs();
        areset = 1;
        #1;
        chk("rstmid cmd_ready after", 64'(cmd_ready), 64'd1);
        bad_seen = 0;
        repeat (3) begin
            @(negedge aclk);
            #1;
            if (done || bus.awvalid || bus.wvalid || bus.arvalid) bad_seen = 1;
        end
        chk("rstmid quiet after", 64'(bad_seen), 64'd0);

        // Randomized commands against the rule-based model.
        for (int t = 0; t < 25; t++) begin
            bit          wr;
            logic [31:0] addr;
            int          len, pct, eb;
            logic [1:0]  b, er;
            wr   = 1'($urandom_range(1));
            len  = ($urandom_range(7) == 0) ? int'($urandom_range(40, 16)) : int'($urandom_range(15));
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(2) == 0) addr[11:0] = 12'hFC0 + 12'($urandom_range(15) * 4);
            b    = 2'($urandom_range(3));
            pct  = int'($urandom_range(100, 40));
            for (int i = 0; i < 257; i++)
                rr_tbl[i] = ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'b00;
            bad_rlast = ($urandom_range(4) == 0) ? int'($urandom_range(len)) : -1;
            er = model_resp(wr, addr, len, b);
            eb = model_reject(addr, len) ? 0 : len + 1;
            run_txn($sformatf("rnd%0d", t), wr, addr, 8'(len), b, pct, er, eb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
